// File: rtl/user_cnn_mac_sbr_if.sv
// rtl/user_cnn_mac_sbr_if.sv - OBI request/response bundle for the CNN MAC subordinate
interface user_cnn_mac_sbr_if #(
    parameter int IdWidth = 1
);
    logic               req_i;
    logic               we_i;
    logic [3:0]         be_i;
    logic [31:0]        addr_i;
    logic [31:0]        wdata_i;
    logic [IdWidth-1:0] aid_i;
    logic               gnt_o;
    logic               rvalid_o;
    logic [31:0]        rdata_o;
    logic [IdWidth-1:0] rid_o;
    logic               err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, aid_i,
        input  gnt_o, rvalid_o, rdata_o, rid_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, aid_i,
        output gnt_o, rvalid_o, rdata_o, rid_o, err_o
    );
endinterface

// File: rtl/user_cnn_mac_sbr.sv
// rtl/user_cnn_mac_sbr.sv - OBI subordinate with int8 ACT/WGT buffers and a sequential MAC engine
// Optional ReLU clamp of the final result is built when USER_CNN_RELU_EN is defined.
module user_cnn_mac_sbr #(
    parameter int Depth    = 16,
    parameter int AccWidth = 32,
    parameter int IdWidth  = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    user_cnn_mac_sbr_if.slave   bus,
    output logic                done_irq_o
);
    localparam int IW = $clog2(Depth);
    localparam int LW = IW + 1;
    localparam logic [9:0] ACT_BASE = 10'h040;
    localparam logic [9:0] ACT_END  = 10'(64 + Depth);
    localparam logic [9:0] WGT_BASE = 10'h080;
    localparam logic [9:0] WGT_END  = 10'(128 + Depth);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       len_q;
    logic [IW-1:0]       idx_q;
    logic [AccWidth-1:0] acc_q;
    logic [AccWidth-1:0] result_q;
    logic                done_q;
    logic                irq_q;
    logic                rvalid_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic [IdWidth-1:0]  rid_q;

    logic signed [7:0]   act_mem [Depth];
    logic signed [7:0]   wgt_mem [Depth];

    logic [9:0]          word;
    logic [IW-1:0]       buf_idx;
    logic                is_ctrl, is_len, is_status, is_result, is_act, is_wgt;
    logic                busy, bad_addr, req_err, wr_ok;
    logic                start_cmd, clr_cmd;
    logic                launch, zero_done, finish, last;
    logic signed [15:0]  prod;
    logic [AccWidth-1:0] acc_next, final_val;
    logic [31:0]         ctrl_rd, rd_mux;
    logic                unused_bits;

    assign word      = bus.addr_i[11:2];
    assign buf_idx   = word[IW-1:0];
    assign is_ctrl   = (word == 10'd0);
    assign is_len    = (word == 10'd1);
    assign is_status = (word == 10'd2);
    assign is_result = (word == 10'd3);
    assign is_act    = (word >= ACT_BASE) && (word < ACT_END);
    assign is_wgt    = (word >= WGT_BASE) && (word < WGT_END);
    assign busy      = (state_q == RUN);
    assign bad_addr  = !(is_ctrl || is_len || is_status || is_result || is_act || is_wgt);

    // Writes to read-only registers, and buffer/LEN writes during a run, are rejected.
    assign req_err = bad_addr ||
                     (bus.we_i && (is_status || is_result)) ||
                     (bus.we_i && busy && (is_len || is_act || is_wgt));
    assign wr_ok     = bus.req_i && bus.we_i && !req_err;
    assign start_cmd = wr_ok && is_ctrl && bus.wdata_i[0];
    assign clr_cmd   = wr_ok && is_ctrl && bus.wdata_i[1];

    assign last     = ({1'b0, idx_q} == (len_q - LW'(1)));
    assign prod     = act_mem[idx_q] * wgt_mem[idx_q];
    assign acc_next = acc_q + {{(AccWidth-16){prod[15]}}, prod};

`ifdef USER_CNN_RELU_EN
    logic relu_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            relu_q <= 1'b0;
        end else if (wr_ok && is_ctrl) begin
            relu_q <= bus.wdata_i[2];
        end
    end

    assign ctrl_rd   = {29'd0, relu_q, 2'd0};
    assign final_val = (relu_q && acc_next[AccWidth-1]) ? '0 : acc_next;
`else
    assign ctrl_rd   = 32'd0;
    assign final_val = acc_next;
`endif

    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        zero_done = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_cmd) begin
                    if (len_q != '0) begin
                        launch  = 1'b1;
                        state_d = RUN;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ok && is_len) begin
                len_q <= (bus.wdata_i > 32'(Depth)) ? LW'(Depth) : bus.wdata_i[LW-1:0];
            end
            if (launch) begin
                idx_q <= '0;
                acc_q <= '0;
            end else if (busy) begin
                idx_q <= idx_q + IW'(1);
                acc_q <= acc_next;
            end
            // CLR is ordered before START/completion so those may still set done.
            if (clr_cmd) begin
                done_q <= 1'b0;
                if (!busy) begin
                    result_q <= '0;
                end
            end
            if (zero_done) begin
                result_q <= '0;
                done_q   <= 1'b1;
            end
            if (finish) begin
                result_q <= final_val;
                done_q   <= 1'b1;
            end
            irq_q <= zero_done || finish;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && is_act) begin
            act_mem[buf_idx] <= bus.wdata_i[7:0];
        end
        if (wr_ok && is_wgt) begin
            wgt_mem[buf_idx] <= bus.wdata_i[7:0];
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        if (is_ctrl) begin
            rd_mux = ctrl_rd;
        end else if (is_len) begin
            rd_mux = 32'(len_q);
        end else if (is_status) begin
            rd_mux = {30'd0, done_q, busy};
        end else if (is_result) begin
            rd_mux = 32'($signed(result_q));
        end else if (is_act) begin
            rd_mux = {{24{act_mem[buf_idx][7]}}, act_mem[buf_idx]};
        end else if (is_wgt) begin
            rd_mux = {{24{wgt_mem[buf_idx][7]}}, wgt_mem[buf_idx]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= bus.req_i;
            err_q    <= bus.req_i && req_err;
            rdata_q  <= (bus.req_i && !bus.we_i && !req_err) ? rd_mux : 32'd0;
            if (bus.req_i) begin
                rid_q <= bus.aid_i;
            end
        end
    end

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = err_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.rid_o    = rid_q;
    assign done_irq_o   = irq_q;

    assign unused_bits = ^{bus.be_i, bus.addr_i[31:12], bus.addr_i[1:0]};
endmodule

// File: tb/tb_user_cnn_mac_sbr.sv
// tb/tb_user_cnn_mac_sbr.sv - table, hand-sequence and randomized checks for user_cnn_mac_sbr
module tb_user_cnn_mac_sbr;
    localparam int DEPTH = 16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic done_irq;
    always #5 clk = ~clk;

    user_cnn_mac_sbr_if #(.IdWidth(1)) bus ();

    user_cnn_mac_sbr #(.Depth(DEPTH), .AccWidth(32), .IdWidth(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .done_irq_o (done_irq)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int irq_count = 0;
    int irq_cyc = -1;
    int start_cyc = 0;

    int act_m [DEPTH];
    int wgt_m [DEPTH];
    int len_m;
    int relu_m = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done_irq === 1'b1) begin
            irq_count <= irq_count + 1;
            irq_cyc   <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic er);
        logic id;
        id = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.be_i    = 4'hF;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        bus.aid_i   = id;
        #1;
        chk("gnt", 32'(bus.gnt_o), 32'd1);
        @(posedge clk);
        #1;
        chk("rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("rid", 32'(bus.rid_o), 32'(id));
        rd = bus.rdata_o;
        er = bus.err_o;
        bus.req_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic er;
        op(1'b1, addr, data, rd, er);
        chk("wr_err", 32'(er), 32'd0);
    endtask

    task automatic wr_bad(input string name, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic er;
        op(1'b1, addr, data, rd, er);
        chk(name, 32'(er), 32'd1);
        chk({name, "_rdata"}, rd, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic er;
        op(1'b0, addr, 32'd0, rd, er);
        chk({name, "_err"}, 32'(er), 32'd0);
        chk(name, rd, exp);
    endtask

    task automatic start_run();
        wr(32'h000, 32'h1 | (32'(relu_m) << 2));
        start_cyc = cyc;
    endtask

    task automatic wait_idle();
        logic [31:0] rd;
        logic er;
        int n = 0;
        do begin
            op(1'b0, 32'h008, 32'd0, rd, er);
            n++;
        end while (rd[0] && n < 64);
        chk("idle_timeout", 32'(rd[0]), 32'd0);
    endtask

    function automatic int expected_result();
        int s = 0;
        for (int i = 0; i < len_m; i++) s += act_m[i] * wgt_m[i];
        if (relu_m != 0 && s < 0) s = 0;
        return s;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [31:0] rd;
        logic er;
        int irq0;
        int lenw;
        logic [31:0] d;

        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t tbl[$];
        logic [31:0] rd;
        logic er;
        int irq0;
        int lenw;
        logic [31:0] d;

        rst = 1'b1;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0;
        bus.addr_i = '0; bus.wdata_i = '0; bus.aid_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_rdata", bus.rdata_o, 32'd0);
        chk("rst_irq", 32'(done_irq), 32'd0);
        rst = 1'b0;

        // First access: rvalid low before the grant edge, high exactly one cycle later with rid=1.
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h2000_1008; bus.aid_i = 1'b1;
        #1;
        chk("gnt_comb", 32'(bus.gnt_o), 32'd1);
        chk("rvalid_early", 32'(bus.rvalid_o), 32'd0);
        @(posedge clk); #1;
        chk("rvalid_1cyc", 32'(bus.rvalid_o), 32'd1);
        chk("rid_echo", 32'(bus.rid_o), 32'd1);
        chk("status_rst", bus.rdata_o, 32'd0);
        bus.req_i = 1'b0;
        @(posedge clk); #1;
        chk("rvalid_drop", 32'(bus.rvalid_o), 32'd0);

        tbl.push_back('{1'b0, 32'h00C, 32'd0, 32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'h004, 32'd0, 32'd0, 1'b0});
        tbl.push_back('{1'b1, 32'h004, 32'd40, 32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'h004, 32'd0, 32'd16, 1'b0});
        tbl.push_back('{1'b1, 32'h004, 32'd3, 32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'h004, 32'd0, 32'd3, 1'b0});
        tbl.push_back('{1'b1, 32'h004, 32'd17, 32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'h004, 32'd0, 32'd16, 1'b0});
        tbl.push_back('{1'b1, 32'h008, 32'd5, 32'd0, 1'b1});
        tbl.push_back('{1'b1, 32'h00C, 32'd5, 32'd0, 1'b1});
        tbl.push_back('{1'b0, 32'h300, 32'd0, 32'd0, 1'b1});
        tbl.push_back('{1'b1, 32'h300, 32'd7, 32'd0, 1'b1});
        tbl.push_back('{1'b0, 32'h010, 32'd0, 32'd0, 1'b1});
        tbl.push_back('{1'b0, 32'h140, 32'd0, 32'd0, 1'b1});
        tbl.push_back('{1'b1, 32'h240, 32'd1, 32'd0, 1'b1});
        tbl.push_back('{1'b1, 32'h100, 32'h1234_56FB, 32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'h100, 32'd0, 32'hFFFF_FFFB, 1'b0});
        tbl.push_back('{1'b0, 32'h102, 32'd0, 32'hFFFF_FFFB, 1'b0});
        tbl.push_back('{1'b1, 32'h23C, 32'h0000_0007, 32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'h23C, 32'd0, 32'd7, 1'b0});
        tbl.push_back('{1'b0, 32'h000, 32'd0, 32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'h008, 32'd0, 32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'h00C, 32'd0, 32'd0, 1'b0});
        foreach (tbl[i]) begin
            op(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // Basic dot product 1*5+2*6+3*7+4*8 = 70, irq exactly LEN cycles after START edge.
        for (int i = 0; i < DEPTH; i++) begin
            wr(32'h100 + 32'(4 * i), (i < 4) ? 32'(i + 1) : 32'd0);
            wr(32'h200 + 32'(4 * i), (i < 4) ? 32'(i + 5) : 32'd9);
        end
        wr(32'h004, 32'd4);
        irq0 = irq_count;
        start_run();
        rd_chk("status_busy", 32'h008, 32'd1);
        wait_idle();
        rd_chk("result_70", 32'h00C, 32'd70);
        rd_chk("status_done", 32'h008, 32'd2);
        chk("irq_once", 32'(irq_count - irq0), 32'd1);
        chk("irq_time", 32'(irq_cyc), 32'(start_cyc + 4));

        // Busy window: LEN=16, ACT[4..] are 0 so the answer is still 70.
        wr(32'h004, 32'd16);
        start_run();
        wr_bad("busy_act_err", 32'h100, 32'd55);
        wr_bad("busy_len_err", 32'h004, 32'd2);
        wr_bad("busy_bad_err", 32'h300, 32'd1);
        wr(32'h000, 32'd1);
        rd_chk("busy_result_prev", 32'h00C, 32'd70);
        wr(32'h000, 32'd2);
        rd_chk("busy_clr_status", 32'h008, 32'd1);
        rd_chk("busy_result_kept", 32'h00C, 32'd70);
        wait_idle();
        rd_chk("result_70b", 32'h00C, 32'd70);
        rd_chk("status_done2", 32'h008, 32'd2);
        rd_chk("act0_kept", 32'h100, 32'd1);
        rd_chk("len_kept", 32'h004, 32'd16);

        // Full negative range: 16 * (-128 * -128).
        for (int i = 0; i < DEPTH; i++) begin
            wr(32'h100 + 32'(4 * i), 32'h80);
            wr(32'h200 + 32'(4 * i), 32'h80);
        end
        start_run();
        wait_idle();
        rd_chk("result_262144", 32'h00C, 32'd262144);

        // CLR and START together with LEN=1: -128 * 127.
        wr(32'h200, 32'h7F);
        wr(32'h004, 32'd1);
        irq0 = irq_count;
        wr(32'h000, 32'd3);
        start_cyc = cyc;
        wait_idle();
        rd_chk("result_c080", 32'h00C, 32'hFFFF_C080);
        chk("irq_time_len1", 32'(irq_cyc), 32'(start_cyc + 1));

        // LEN=0 start completes immediately with RESULT cleared.
        wr(32'h004, 32'd0);
        irq0 = irq_count;
        start_run();
        rd_chk("len0_status", 32'h008, 32'd2);
        rd_chk("len0_result", 32'h00C, 32'd0);
        chk("len0_irq", 32'(irq_count - irq0), 32'd1);
        chk("len0_irq_time", 32'(irq_cyc), 32'(start_cyc));
        wr(32'h000, 32'd2);
        rd_chk("clr_status", 32'h008, 32'd0);

`ifdef USER_CNN_RELU_EN
        wr(32'h100, 32'hFD);
        wr(32'h200, 32'h05);
        wr(32'h004, 32'd1);
        wr(32'h000, 32'h5);
        wait_idle();
        rd_chk("relu_result", 32'h00C, 32'd0);
        rd_chk("relu_ctrl", 32'h000, 32'd4);
        wr(32'h000, 32'h1);
        wait_idle();
        rd_chk("norelu_result", 32'h00C, 32'hFFFF_FFF1);
        rd_chk("norelu_ctrl", 32'h000, 32'd0);
`endif

        // Randomized runs against the arithmetic model.
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                d = $urandom;
                wr(32'h100 + 32'(4 * i), d);
                act_m[i] = int'(byte'(d[7:0]));
                d = $urandom;
                wr(32'h200 + 32'(4 * i), d);
                wgt_m[i] = int'(byte'(d[7:0]));
            end
            lenw = (it == 0) ? 0 : $urandom_range(0, 40);
            wr(32'h004, 32'(lenw));
            len_m = (lenw > DEPTH) ? DEPTH : lenw;
            rd_chk("rnd_len", 32'h004, 32'(len_m));
`ifdef USER_CNN_RELU_EN
            relu_m = $urandom_range(0, 1);
`endif
            irq0 = irq_count;
            start_run();
            wait_idle();
            rd_chk("rnd_result", 32'h00C, 32'(expected_result()));
            rd_chk("rnd_status", 32'h008, 32'd2);
            chk("rnd_irq_once", 32'(irq_count - irq0), 32'd1);
            chk("rnd_irq_time", 32'(irq_cyc), 32'(start_cyc + len_m));
            lenw = $urandom_range(0, DEPTH - 1);
            rd_chk("rnd_act_rb", 32'h100 + 32'(4 * lenw), 32'(act_m[lenw]));
        end
        relu_m = 0;

        // Reset in the middle of a run aborts without a completion pulse.
        for (int i = 0; i < DEPTH; i++) wr(32'h100 + 32'(4 * i), 32'h11);
        wr(32'h004, 32'd16);
        start_run();
        irq0 = irq_count;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rvalid", 32'(bus.rvalid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_irq", 32'(irq_count - irq0), 32'd0);
        rd_chk("midrst_status", 32'h008, 32'd0);
        rd_chk("midrst_result", 32'h00C, 32'd0);
        rd_chk("midrst_len", 32'h004, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
